truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Sequences a 3-input combinational gate (Cello truth-table netlist) through all 8 input vectors.
//  Waits a programmable settle time per vector, samples the gate output and assembles the 8-bit truth table.
//  Compares the table against an expected hex ID (e.g. 8'h27); reports pass/fail and a per-row mismatch mask.
//  Sits between the test/config controller and the gate under test in the gate-characterisation datapath.
// PARAMETERS
//  SETTLE_CYCLES  16  cycles each vector is held before sampling; legal range >=1
// PORTS
//  clk            in   1  single clock; all state on rising edge
//  rst_n          in   1  asynchronous, active-low reset
//  start          in   1  begin sweep; honoured only in IDLE
//  abort          in   1  cancel sweep in progress
//  expected       in   8  expected truth-table ID; latched on accepted start
//  in1,in2,in3    out  1  registered input vector driven to the gate; {in1,in2,in3}=idx
//  dut_out        in   1  gate output
//  busy           out  1  high while sweep active
//  done           out  1  one-cycle pulse at sweep completion
//  table_out      out  8  captured truth table; bit[7-idx] = output for vector idx
//  pass           out  1  table_out==expected; valid from done, held until next start
//  mismatch_mask  out  8  table_out ^ expected; same timing as pass
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, {in1,in2,in3}=3'b000, busy=0, done=0,
//   table_out=0, pass=0, mismatch_mask=0, idx=0, settle counter=0.
//  States: IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE) -> IDLE.
//  IDLE: vector held at 000. start=1 at edge k: latch expected, idx=0, drive 000, counter=SETTLE_CYCLES-1,
//   clear table_out/pass/mismatch_mask, -> SETTLE; busy=1 from k+1.
//  SETTLE: occupies exactly SETTLE_CYCLES cycles (counter down to 0), vector held stable, -> SAMPLE.
//  SAMPLE: occupies S cycles (S=1, or 3 with majority option); captured bit written to table_out[7-idx].
//   idx<7: idx++, vector updated on the same edge, counter reloaded, -> SETTLE.
//   idx==7: -> DONE.
//  DONE: one cycle; done=1, busy=0, pass and mismatch_mask updated from final table; vector returns to 000; -> IDLE.
//  Latency: start accepted at edge k -> done high in cycle k+8*(SETTLE_CYCLES+S)+1.
//  start while busy or in DONE: ignored, no effect on the sweep or the latched expected.
//  abort while busy: next edge -> IDLE, busy=0, no done pulse, vector=000, table_out keeps partial bits,
//   pass=0, mismatch_mask=0. abort and start together in IDLE: abort wins (start ignored).
//  abort in IDLE/DONE: no effect (done pulse still completes).
//  rst_n low mid-sweep: immediate return to reset values; no done.
//  Back-to-back: start may be accepted in the cycle directly after DONE.
// CONFIGURATION
//  TTS_MAJORITY_VOTE_EN defined: SAMPLE lasts 3 cycles; captured bit = majority of the 3 dut_out samples (S=3).
//  Undefined: SAMPLE lasts 1 cycle; captured bit = single dut_out sample (S=1).
//  Ports and all other behaviour identical in both builds.
// STRUCTURE
//  Package truth_table_pkg:
//   - state enum {IDLE,SETTLE,SAMPLE,DONE}
//   - TT_INPUTS=3, TT_ROWS=8, TT_WIDTH=8
//   - function row_bit(idx)=7-idx
//  One sub-module, tts_settle_timer: loadable down-counter, width $clog2(SETTLE_CYCLES+1), load/zero flag.
//  FSM, idx counter, capture/vote logic in the top.
// TESTING
//  1. SETTLE=4, gate model 0x27, expected=8'h27, start -> table_out=8'h27, pass=1, mask=8'h00,
//     done at k+41 (S=1) / k+57 (S=3).
//  2. dut_out stuck 0, expected=8'h27 -> table_out=8'h00, pass=0, mask=8'h27, one done pulse.
//  3. Vector order: log {in1,in2,in3} at each SAMPLE -> 000,001,...,111, each held exactly SETTLE+S cycles,
//     stable with no glitch.
//  4. start re-pulsed mid-sweep with expected=8'hFF -> ignored; result still compared against 8'h27.
//  5. abort during idx=3 -> busy low next cycle, vector 000, no done, pass=0;
//     new start then gives a full correct sweep.
//  6. rst_n low at idx=5 -> all outputs at reset values asynchronously;
//     with TTS_MAJORITY_VOTE_EN, a 1-cycle dut_out glitch in SAMPLE -> table unaffected.

Source files
------------

// File: rtl/truth_table_pkg.sv
// ============================================================================
// Module  : truth_table_pkg
// Brief   : Shared types and constants for the 3-input truth-table sweeper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package truth_table_pkg;

    localparam int TT_INPUTS = 3;
    localparam int TT_ROWS   = 8;
    localparam int TT_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tts_state_e;

    // Row 0 (vector 000) lands in the MSB so the table reads like a Cello hex ID.
    function automatic logic [TT_INPUTS-1:0] row_bit(input logic [TT_INPUTS-1:0] idx);
        return TT_INPUTS'(TT_ROWS - 1) - idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tts_settle_timer.sv
// ============================================================================
// Module  : tts_settle_timer
// Brief   : Loadable down-counter timing how long each input vector settles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tts_settle_timer #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic zero_o
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Loading SETTLE_CYCLES-1 makes the zero flag rise on the last settle cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(SETTLE_CYCLES - 1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// ============================================================================
// Module  : truth_table_sweeper
// Brief   : Walks a 3-input gate through all 8 vectors, captures its truth
//           table and compares it with an expected ID. Define
//           TTS_MAJORITY_VOTE_EN for a 3-sample majority-voted capture.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [TT_WIDTH-1:0] expected,
    output logic                in1,
    output logic                in2,
    output logic                in3,
    input  logic                dut_out,
    output logic                busy,
    output logic                done,
    output logic [TT_WIDTH-1:0] table_out,
    output logic                pass,
    output logic [TT_WIDTH-1:0] mismatch_mask
);

    tts_state_e           state_q, state_d;
    logic [TT_INPUTS-1:0] idx_q, idx_d;
    logic [TT_INPUTS-1:0] vec_q, vec_d;
    logic [TT_WIDTH-1:0]  exp_q, exp_d;
    logic [TT_WIDTH-1:0]  table_q, table_d;
    logic                 pass_q, pass_d;
    logic [TT_WIDTH-1:0]  mask_q, mask_d;

    logic timer_load;
    logic timer_zero;
    logic sample_last;
    logic captured;

    tts_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (timer_load),
        .en_i   (state_q == SETTLE),
        .zero_o (timer_zero)
    );

`ifdef TTS_MAJORITY_VOTE_EN
    logic [1:0] samp_cnt_q;
    logic [1:0] vote_q;

    // Two earlier samples are kept; the third comes straight from dut_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_cnt_q <= '0;
            vote_q     <= '0;
        end else if (state_q == SAMPLE) begin
            samp_cnt_q <= samp_cnt_q + 2'd1;
            vote_q     <= {vote_q[0], dut_out};
        end else begin
            samp_cnt_q <= '0;
        end
    end

    assign sample_last = (samp_cnt_q == 2'd2);
    assign captured    = (vote_q[1] & vote_q[0]) | (vote_q[1] & dut_out) | (vote_q[0] & dut_out);
`else
    assign sample_last = 1'b1;
    assign captured    = dut_out;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        vec_d      = vec_q;
        exp_d      = exp_q;
        table_d    = table_q;
        pass_d     = pass_q;
        mask_d     = mask_q;
        timer_load = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    exp_d      = expected;
                    idx_d      = '0;
                    vec_d      = '0;
                    table_d    = '0;
                    pass_d     = 1'b0;
                    mask_d     = '0;
                    timer_load = 1'b1;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    vec_d   = '0;
                    pass_d  = 1'b0;
                    mask_d  = '0;
                end else if (timer_zero) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    vec_d   = '0;
                    pass_d  = 1'b0;
                    mask_d  = '0;
                end else if (sample_last) begin
                    table_d[row_bit(idx_q)] = captured;
                    if (idx_q == TT_INPUTS'(TT_ROWS - 1)) begin
                        // Verdict is taken from the completed table so it is valid during DONE.
                        pass_d  = (table_d == exp_q);
                        mask_d  = table_d ^ exp_q;
                        vec_d   = '0;
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        vec_d      = idx_q + 1'b1;
                        timer_load = 1'b1;
                        state_d    = SETTLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
            exp_q   <= '0;
            table_q <= '0;
            pass_q  <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            exp_q   <= exp_d;
            table_q <= table_d;
            pass_q  <= pass_d;
            mask_q  <= mask_d;
        end
    end

    assign {in1, in2, in3} = vec_q;
    assign busy            = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done            = (state_q == DONE);
    assign table_out       = table_q;
    assign pass            = pass_q;
    assign mismatch_mask   = mask_q;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// ============================================================================
// Module  : tb_truth_table_sweeper
// Brief   : Self-checking bench for truth_table_sweeper against a timeline
//           model of the sweep (honours TTS_MAJORITY_VOTE_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_truth_table_sweeper;

    localparam int SC = 4;
`ifdef TTS_MAJORITY_VOTE_EN
    localparam int S       = 3;
    localparam int LAT_EXP = 57;
`else
    localparam int S       = 1;
    localparam int LAT_EXP = 41;
`endif
    localparam int P     = SC + S;
    localparam int SWEEP = 8 * P;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic       abort    = 1'b0;
    logic [7:0] expected = 8'h00;
    logic       in1, in2, in3;
    logic       dut_out;
    logic       busy, done, pass;
    logic [7:0] table_out, mismatch_mask;

    logic [7:0] gate_tt  = 8'h27;
    logic       stuck0   = 1'b0;
    logic       glitch   = 1'b0;
    logic       check_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;
    int done_cnt = 0;
    int k_last   = 0;

    bit         m_active = 1'b0;
    int         m_k      = 0;
    logic [7:0] m_exp    = 8'h00;
    logic [7:0] m_table  = 8'h00;
    logic       m_pass   = 1'b0;
    logic [7:0] m_mask   = 8'h00;

    truth_table_sweeper #(
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .expected      (expected),
        .in1           (in1),
        .in2           (in2),
        .in3           (in3),
        .dut_out       (dut_out),
        .busy          (busy),
        .done          (done),
        .table_out     (table_out),
        .pass          (pass),
        .mismatch_mask (mismatch_mask)
    );

    always #5 clk = ~clk;

    // Gate under test: vector v answers with gate_tt[7-v].
    always_comb begin
        logic [2:0] r;
        r       = 3'd7 - {in1, in2, in3};
        dut_out = stuck0 ? 1'b0 : (gate_tt[r] ^ glitch);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, req, edge_n);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no event, required it within the cycle budget (edge %0d)", name, edge_n);
    endtask

    // Timeline model: a sweep accepted at edge k captures vector v at edge k+(v+1)P,
    // is busy for 8P cycles, then shows one DONE cycle.
    always @(posedge clk) begin : p_model
        int d;
        int v;
        bit was_idle;
        edge_n = edge_n + 1;
        if (!rst_n) begin
            m_active = 1'b0;
            m_table  = 8'h00;
            m_pass   = 1'b0;
            m_mask   = 8'h00;
        end else begin
            was_idle = !m_active;
            if (m_active) begin
                d = edge_n - m_k;
                if (d == SWEEP + 1) begin
                    m_active = 1'b0;
                end else if (abort) begin
                    m_active = 1'b0;
                    m_pass   = 1'b0;
                    m_mask   = 8'h00;
                end else if (d % P == 0) begin
                    v = d / P - 1;
                    m_table[7-v] = stuck0 ? 1'b0 : gate_tt[7-v];
                    if (v == 7) begin
                        m_pass = (m_table == m_exp);
                        m_mask = m_table ^ m_exp;
                    end
                end
            end
            if (was_idle && start && !abort) begin
                m_active = 1'b1;
                m_k      = edge_n;
                m_exp    = expected;
                m_table  = 8'h00;
                m_pass   = 1'b0;
                m_mask   = 8'h00;
            end
        end
    end

    always @(negedge clk) begin : p_compare
        int         d;
        logic       eb;
        logic       ed;
        logic [2:0] ev;
        if (check_en) begin
            eb = 1'b0;
            ed = 1'b0;
            ev = 3'd0;
            if (m_active) begin
                d = edge_n - m_k;
                if (d < SWEEP) begin
                    eb = 1'b1;
                    ev = 3'(d / P);
                end else if (d == SWEEP) begin
                    ed = 1'b1;
                end
            end
            chk("busy", 32'(busy), 32'(eb));
            chk("done", 32'(done), 32'(ed));
            chk("vector", 32'({in1, in2, in3}), 32'(ev));
            chk("table_out", 32'(table_out), 32'(m_table));
            chk("pass", 32'(pass), 32'(m_pass));
            chk("mismatch_mask", 32'(mismatch_mask), 32'(m_mask));
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic pulse_start(input logic [7:0] e);
        @(negedge clk);
        #1 start = 1'b1;
        expected = e;
        @(posedge clk);
        #1 start = 1'b0;
        k_last = edge_n;
    endtask

    task automatic pulse_abort();
        @(negedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < SWEEP + 20);
        if (done !== 1'b1) timeout(name);
    endtask

    task automatic wait_vec(input logic [2:0] v, input string name);
        int n = 0;
        while (!(busy === 1'b1 && {in1, in2, in3} === v) && n < SWEEP + 20) begin
            @(negedge clk);
            n++;
        end
        if (!(busy === 1'b1 && {in1, in2, in3} === v)) timeout(name);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || done !== 1'b0) && n < 2 * SWEEP + 20) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0 || done !== 1'b0) timeout("wait_idle");
        @(negedge clk);
    endtask

    initial begin : p_stim
        int         k;
        int         dc;
        logic [7:0] e;

        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_vector", 32'({in1, in2, in3}), 32'd0);
        chk("reset_table", 32'(table_out), 32'd0);
        chk("reset_pass", 32'(pass), 32'd0);
        chk("reset_mask", 32'(mismatch_mask), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_en = 1'b1;

        // Nominal sweep of gate 0x27; cycle n is the one following edge n-1.
        gate_tt = 8'h27;
        pulse_start(8'h27);
        k = k_last;
        wait_done("t1_done");
        chk("t1_latency", 32'(edge_n - k + 1), 32'(LAT_EXP));
        chk("t1_table", 32'(table_out), 32'h27);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_mask", 32'(mismatch_mask), 32'h00);

        // Start held through DONE is ignored there and accepted the cycle after.
        #1 start = 1'b1;
        expected = 8'h27;
        @(negedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        k = edge_n;
        wait_done("b2b_done");
        chk("b2b_latency", 32'(edge_n - k + 1), 32'(LAT_EXP));
        chk("b2b_pass", 32'(pass), 32'd1);

        // Output stuck at 0.
        wait_idle();
        stuck0 = 1'b1;
        dc = done_cnt;
        pulse_start(8'h27);
        wait_done("t2_done");
        chk("t2_table", 32'(table_out), 32'h00);
        chk("t2_pass", 32'(pass), 32'd0);
        chk("t2_mask", 32'(mismatch_mask), 32'h27);
        repeat (3) @(negedge clk);
        chk("t2_done_pulses", 32'(done_cnt - dc), 32'd1);
        stuck0 = 1'b0;

        // Start re-pulsed mid-sweep must not replace the latched expected.
        wait_idle();
        pulse_start(8'h27);
        repeat (12) @(negedge clk);
        pulse_start(8'hFF);
        wait_done("t4_done");
        chk("t4_pass", 32'(pass), 32'd1);
        chk("t4_mask", 32'(mismatch_mask), 32'h00);

        // Abort at vector 3, then a clean sweep.
        wait_idle();
        dc = done_cnt;
        pulse_start(8'h27);
        wait_vec(3'd3, "t5_vec3");
        pulse_abort();
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_vector", 32'({in1, in2, in3}), 32'd0);
        chk("t5_pass", 32'(pass), 32'd0);
        repeat (SWEEP + 5) @(negedge clk);
        chk("t5_no_done", 32'(done_cnt - dc), 32'd0);
        pulse_start(8'h27);
        wait_done("t5_resweep");
        chk("t5_re_table", 32'(table_out), 32'h27);
        chk("t5_re_pass", 32'(pass), 32'd1);

        // Asynchronous reset at vector 5.
        wait_idle();
        pulse_start(8'h27);
        wait_vec(3'd5, "t6_vec5");
        check_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_vector", 32'({in1, in2, in3}), 32'd0);
        chk("t6_table", 32'(table_out), 32'd0);
        chk("t6_pass", 32'(pass), 32'd0);
        chk("t6_mask", 32'(mismatch_mask), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_en = 1'b1;

`ifdef TTS_MAJORITY_VOTE_EN
        // One corrupted sample per vector must be outvoted.
        pulse_start(8'h27);
        for (int v = 0; v < 8; v++) begin
            int n = 0;
            while (edge_n - m_k != v * P + SC + (v % 3) && n < SWEEP + 20) begin
                @(negedge clk);
                n++;
            end
            #1 glitch = 1'b1;
            @(negedge clk);
            #1 glitch = 1'b0;
        end
        wait_done("glitch_done");
        chk("glitch_table", 32'(table_out), 32'h27);
        chk("glitch_pass", 32'(pass), 32'd1);
        wait_idle();
`endif

        // Randomised gates, expectations, stray starts and aborts.
        for (int it = 0; it < 10; it++) begin
            int r;
            wait_idle();
            gate_tt = 8'($urandom);
            e = ($urandom_range(0, 1) == 1) ? gate_tt : 8'($urandom);
            pulse_start(e);
            r = $urandom_range(0, 2);
            repeat ($urandom_range(1, SWEEP)) @(negedge clk);
            if (r == 0) begin
                pulse_abort();
            end else if (r == 1) begin
                pulse_start(8'($urandom));
            end
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
